// File: rtl/frame_read_addr_gen_pkg.sv
// Shared types and index helpers for the frame read-command generator.
// Mirror math runs on wide signed indices so the extension never wraps.
package frame_rag_pkg;

  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int IDX_W      = 64;

  typedef logic [ADDR_W_DEF-1:0]   addr_t;
  typedef logic signed [IDX_W-1:0] idx_t;

  // Reflects an extended line index back into 0..n-1 about the frame edges.
  function automatic idx_t mirror_idx(input idx_t k, input idx_t n);
    if (k < 0) begin
      return -k;
    end else if (k > n - idx_t'(1)) begin
      return (n - idx_t'(1)) + (n - idx_t'(1)) - k;
    end else begin
      return k;
    end
  endfunction

  function automatic bit ext_ok(input int ext);
    return (ext >= 2) && ((ext % 2) == 0);
  endfunction

endpackage

// File: rtl/frame_read_addr_gen_if.sv
// Read-command channel between the address generator and the AR arbiter.
interface frame_read_addr_gen_if #(
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] even_addr;
  logic [ADDR_W-1:0] odd_addr;
  logic [7:0]        len;
  logic              line_last;
  logic              frame_last;

  modport master (
    output valid, even_addr, odd_addr, len, line_last, frame_last,
    input  ready
  );

  modport slave (
    input  valid, even_addr, odd_addr, len, line_last, frame_last,
    output ready
  );
endinterface

// File: rtl/frame_read_addr_gen_line_burst_splitter.sv
// Walks one line in bursts of at most MAX_BURST_LEN beats; col is the beat offset.
module line_burst_splitter #(
  parameter int ADDR_W        = 32,
  parameter int MAX_BURST_LEN = 256,
  parameter int BEAT_W        = $clog2(MAX_BURST_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] hsize_i,
  output logic [ADDR_W-1:0] col_o,
  output logic [BEAT_W-1:0] beats_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] col_q;
  logic [ADDR_W-1:0] remaining;

  assign remaining = hsize_i - col_q;
  assign col_o     = col_q;

  always_comb begin
    beats_o = BEAT_W'(MAX_BURST_LEN);
    last_o  = 1'b0;
    if (remaining <= ADDR_W'(MAX_BURST_LEN)) begin
      beats_o = BEAT_W'(remaining);
      last_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
    end else if (clear_i) begin
      col_q <= '0;
    end else if (step_i) begin
      col_q <= col_q + ADDR_W'(beats_o);
    end
  end

endmodule

// File: rtl/frame_read_addr_gen.sv
// 2-D mirrored-extension read-command generator: one even/odd burst pair per command.
// Define FRAME_RAG_BURST_CNT_EN to add the per-frame accepted-burst counter output.
module frame_read_addr_gen
  import frame_rag_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_BURST_LEN = 256,
  parameter int EXT           = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [ADDR_W-1:0]     stride_i,
  input  logic [ADDR_W-1:0]     vsize_i,
  input  logic [ADDR_W-1:0]     hsize_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o,
  frame_read_addr_gen_if.master cmd
`ifdef FRAME_RAG_BURST_CNT_EN
  ,
  output logic [31:0]           burst_cnt_o
`endif
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BEAT_W = $clog2(MAX_BURST_LEN + 1);
  localparam int K_W    = ADDR_W + 2;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       base_q, stride_q, n_q, hsize_q;
  logic [ADDR_W-1:0]       row_e_q, row_o_q;
  logic signed [K_W-1:0]   k_q;
  logic                    cfg_err_q;
  logic                    cfg_legal, start_acc, handshake, pair_last, split_last;
  logic [ADDR_W-1:0]       col, col_off;
  logic [BEAT_W-1:0]       beats;
  idx_t                    k_ext, n_ext;

  assign cfg_legal = ext_ok(EXT) && (vsize_i > ADDR_W'(EXT)) && (hsize_i != '0);
  assign start_acc = (state_q == IDLE) && start_i;
  assign handshake = (state_q == ISSUE) && cmd.ready;
  assign k_ext     = idx_t'(k_q);
  assign n_ext     = idx_t'(n_q);
  // The pair starting at k is the last one once k+1 reaches N-1+EXT or beyond.
  assign pair_last = (k_ext + idx_t'(2)) >= (n_ext + idx_t'(EXT));
  assign col_off   = col * ADDR_W'(BYTES);
  assign cfg_err_o = cfg_err_q;

  line_burst_splitter #(
    .ADDR_W       (ADDR_W),
    .MAX_BURST_LEN(MAX_BURST_LEN),
    .BEAT_W       (BEAT_W)
  ) u_splitter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(state_q == CALC),
    .step_i (handshake),
    .hsize_i(hsize_q),
    .col_o  (col),
    .beats_o(beats),
    .last_o (split_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = cfg_legal ? CALC : DONE;
      CALC:    state_d = ISSUE;
      ISSUE:   if (handshake && split_last) state_d = pair_last ? DONE : CALC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row addresses are formed once per pair here so ISSUE only adds column offsets.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q    <= '0;
      stride_q  <= '0;
      n_q       <= '0;
      hsize_q   <= '0;
      row_e_q   <= '0;
      row_o_q   <= '0;
      k_q       <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      if (start_acc) begin
        base_q    <= base_addr_i;
        stride_q  <= stride_i;
        n_q       <= vsize_i;
        hsize_q   <= hsize_i;
        k_q       <= -K_W'(EXT);
        cfg_err_q <= !cfg_legal;
      end
      if (state_q == CALC) begin
        row_e_q <= base_q + ADDR_W'(mirror_idx(k_ext, n_ext)) * stride_q;
        row_o_q <= base_q + ADDR_W'(mirror_idx(k_ext + idx_t'(1), n_ext)) * stride_q;
      end
      if (handshake && split_last && !pair_last) begin
        k_q <= k_q + K_W'(2);
      end
    end
  end

`ifdef FRAME_RAG_BURST_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      burst_cnt_o <= '0;
    end else if (start_acc) begin
      burst_cnt_o <= '0;
    end else if (handshake) begin
      burst_cnt_o <= burst_cnt_o + 32'd1;
    end
  end
`endif

  always_comb begin
    busy_o         = (state_q != IDLE);
    done_o         = (state_q == DONE);
    cmd.valid      = 1'b0;
    cmd.even_addr  = '0;
    cmd.odd_addr   = '0;
    cmd.len        = '0;
    cmd.line_last  = 1'b0;
    cmd.frame_last = 1'b0;
    if (state_q == ISSUE) begin
      cmd.valid      = 1'b1;
      cmd.even_addr  = row_e_q + col_off;
      cmd.odd_addr   = row_o_q + col_off;
      cmd.len        = 8'(beats - BEAT_W'(1));
      cmd.line_last  = split_last;
      cmd.frame_last = split_last && pair_last;
    end
  end

endmodule

// File: tb/tb_frame_read_addr_gen.sv
// Scoreboard bench for frame_read_addr_gen: a frame-level reference model fills a
// queue of expected commands that a negedge monitor drains on every handshake.
module tb_frame_read_addr_gen;

  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int MAX_BURST_LEN = 256;
  localparam int EXT           = 4;
  localparam int BYTES         = DATA_W / 8;
  localparam int BOUND         = 5000;

  logic        clk_i       = 1'b0;
  logic        rst_ni      = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [31:0] stride_i    = '0;
  logic [31:0] vsize_i     = '0;
  logic [31:0] hsize_i     = '0;
  logic        start_i     = 1'b0;
  logic        busy_o, done_o, cfg_err_o;
`ifdef FRAME_RAG_BURST_CNT_EN
  logic [31:0] burst_cnt_o;
`endif

  frame_read_addr_gen_if #(.ADDR_W(ADDR_W)) cmd ();

  frame_read_addr_gen #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .MAX_BURST_LEN(MAX_BURST_LEN),
    .EXT          (EXT)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .base_addr_i(base_addr_i),
    .stride_i   (stride_i),
    .vsize_i    (vsize_i),
    .hsize_i    (hsize_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cfg_err_o  (cfg_err_o),
    .cmd        (cmd)
`ifdef FRAME_RAG_BURST_CNT_EN
    ,
    .burst_cnt_o(burst_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] e;
    logic [31:0] o;
    logic [7:0]  len;
    logic        ll;
    logic        fl;
  } cmd_t;

  cmd_t expQ[$];
  int   nCompared   = 0;
  int   nMismatch   = 0;
  int   cyc         = 0;
  int   hsCount     = 0;
  int   lastFlCycle = -1;
  bit   forceLow    = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint mirrorRef(input longint k, input longint n);
    if (k < 0) return -k;
    if (k > n - 1) return 2 * (n - 1) - k;
    return k;
  endfunction

  // Expected command stream straight from the frame rules: pairs of extended rows, each line cut into bursts.
  task automatic buildExpected(input logic [31:0] base, input logic [31:0] stride, input int n, input int h);
    int pairs;
    pairs = (n + 2 * EXT + 1) / 2;
    for (int p = 0; p < pairs; p++) begin
      longint      k;
      logic [31:0] re, ro;
      int          col, b;
      cmd_t        c;
      k   = longint'(2 * p - EXT);
      re  = base + 32'(mirrorRef(k, longint'(n))) * stride;
      ro  = base + 32'(mirrorRef(k + 1, longint'(n))) * stride;
      col = 0;
      while (col < h) begin
        b     = (h - col > MAX_BURST_LEN) ? MAX_BURST_LEN : h - col;
        c.e   = re + 32'(col * BYTES);
        c.o   = ro + 32'(col * BYTES);
        c.len = 8'(b - 1);
        c.ll  = (col + b == h);
        c.fl  = c.ll && (p == pairs - 1);
        expQ.push_back(c);
        col += b;
      end
    end
  endtask

  initial begin
    cmd.ready = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      cmd.ready = forceLow ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  cmd_t prevCmd;
  logic prevValid = 1'b0;
  logic prevReady = 1'b0;
  logic prevRst   = 1'b0;

  always @(negedge clk_i) begin : monitor
    cmd_t x;
    if (rst_ni && prevRst && prevValid && !prevReady) begin
      checkOutput("hold_valid", cmd.valid, 1);
      checkOutput("hold_even", cmd.even_addr, prevCmd.e);
      checkOutput("hold_odd", cmd.odd_addr, prevCmd.o);
      checkOutput("hold_len", cmd.len, prevCmd.len);
      checkOutput("hold_flags", {cmd.line_last, cmd.frame_last}, {prevCmd.ll, prevCmd.fl});
    end
    if (rst_ni && cmd.valid && cmd.ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_cmd", cmd.even_addr, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        x = expQ.pop_front();
        checkOutput("even_addr", cmd.even_addr, x.e);
        checkOutput("odd_addr", cmd.odd_addr, x.o);
        checkOutput("len", cmd.len, x.len);
        checkOutput("line_last", cmd.line_last, x.ll);
        checkOutput("frame_last", cmd.frame_last, x.fl);
      end
      hsCount++;
      if (cmd.frame_last) lastFlCycle = cyc;
    end
    prevValid   = cmd.valid;
    prevReady   = cmd.ready;
    prevRst     = rst_ni;
    prevCmd.e   = cmd.even_addr;
    prevCmd.o   = cmd.odd_addr;
    prevCmd.len = cmd.len;
    prevCmd.ll  = cmd.line_last;
    prevCmd.fl  = cmd.frame_last;
  end

  // One frame: start pulse, bounded wait for done, then timing/count checks; optional stall with ignored start.
  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] stride,
                               input int n, input int h, input bit doStall);
    int startCyc, firstValid, doneCyc, stallAt, expCount, i;
    bit legal;
    legal      = (n > EXT) && (h != 0);
    firstValid = -1;
    doneCyc    = -1;
    stallAt    = -1;
    for (i = 0; i < BOUND && busy_o; i++) begin
      @(negedge clk_i);
      #1;
    end
    if (busy_o) checkOutput("idle_wait_timeout", busy_o, 0);
    if (legal) buildExpected(base, stride, n, h);
    expCount    = expQ.size();
    hsCount     = 0;
    lastFlCycle = -1;
    base_addr_i = base;
    stride_i    = stride;
    vsize_i     = 32'(n);
    hsize_i     = 32'(h);
    start_i     = 1'b1;
    startCyc    = cyc;
    @(negedge clk_i);
    #1;
    start_i = 1'b0;
    for (i = 0; i < BOUND; i++) begin
      if (cmd.valid && firstValid < 0) firstValid = cyc;
      if (doStall && firstValid >= 0) begin
        if (stallAt < 0) begin
          stallAt  = cyc;
          forceLow = 1'b1;
        end
        if (cyc - stallAt == 1) begin
          start_i     = 1'b1;
          base_addr_i = 32'hDEAD_0000;
          vsize_i     = 32'd3;
          hsize_i     = 32'd0;
          stride_i    = 32'd0;
        end
        if (cyc - stallAt == 3) start_i = 1'b0;
        if (cyc - stallAt == 6) forceLow = 1'b0;
      end
      if (done_o) begin
        doneCyc = cyc;
        break;
      end
      @(negedge clk_i);
      #1;
    end
    start_i  = 1'b0;
    forceLow = 1'b0;
    if (doneCyc < 0) begin
      checkOutput("done_timeout", 0, 1);
    end else if (legal) begin
      checkOutput("first_valid_latency", firstValid - startCyc, 2);
      checkOutput("done_after_last", doneCyc - lastFlCycle, 1);
      checkOutput("burst_total", hsCount, expCount);
      checkOutput("queue_empty", expQ.size(), 0);
      checkOutput("cfg_err_legal", cfg_err_o, 0);
    end else begin
      checkOutput("err_done_latency", doneCyc - startCyc, 1);
      checkOutput("err_no_valid", firstValid, -1);
      checkOutput("err_no_cmds", hsCount, 0);
      checkOutput("cfg_err_set", cfg_err_o, 1);
    end
`ifdef FRAME_RAG_BURST_CNT_EN
    checkOutput("burst_cnt", burst_cnt_o, expCount);
`endif
    expQ.delete();
    @(negedge clk_i);
    #1;
    checkOutput("done_one_cycle", done_o, 0);
    checkOutput("busy_after_done", busy_o, 0);
`ifdef FRAME_RAG_BURST_CNT_EN
    checkOutput("burst_cnt_hold", burst_cnt_o, expCount);
`endif
  endtask

  task automatic resetMidFrame();
    int i;
    buildExpected(32'h0, 32'h100, 8, 64);
    hsCount     = 0;
    base_addr_i = 32'h0;
    stride_i    = 32'h100;
    vsize_i     = 32'd8;
    hsize_i     = 32'd64;
    start_i     = 1'b1;
    @(negedge clk_i);
    #1;
    start_i = 1'b0;
    for (i = 0; i < BOUND && (hsCount < 3 || !cmd.valid); i++) begin
      @(negedge clk_i);
      #1;
    end
    if (i == BOUND) checkOutput("reset_wait_timeout", hsCount, 3);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_valid", cmd.valid, 0);
    checkOutput("async_rst_busy", busy_o, 0);
    checkOutput("async_rst_even", cmd.even_addr, 0);
    checkOutput("async_rst_len", cmd.len, 0);
`ifdef FRAME_RAG_BURST_CNT_EN
    checkOutput("async_rst_cnt", burst_cnt_o, 0);
`endif
    expQ.delete();
    repeat (2) @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rb, rs;
    int          rn, rh;
    #3;
    checkOutput("rst_valid", cmd.valid, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_cfg_err", cfg_err_o, 0);
    checkOutput("rst_addrs", {cmd.even_addr, cmd.odd_addr}, 0);
    checkOutput("rst_len_flags", {cmd.len, cmd.line_last, cmd.frame_last}, 0);
`ifdef FRAME_RAG_BURST_CNT_EN
    checkOutput("rst_cnt", burst_cnt_o, 0);
`endif
    @(negedge clk_i);
    #1;
    rst_ni = 1'b1;

    $display("[TB] directed frames");
    applyStimulus(32'h0, 32'h100, 8, 4, 1'b0);
    applyStimulus(32'h0, 32'h1000, 8, 600, 1'b1);
    applyStimulus(32'h200, 32'h80, 7, 16, 1'b0);
    applyStimulus(32'h0, 32'h100, 3, 4, 1'b0);
    applyStimulus(32'h0, 32'h100, 8, 4, 1'b0);
    applyStimulus(32'h0, 32'h100, 8, 0, 1'b0);
    applyStimulus(32'h0, 32'h100, 4, 4, 1'b0);
    applyStimulus(32'h10, 32'h40, 5, 3, 1'b0);
    applyStimulus(32'hFFFF_F000, 32'h800, 6, 256, 1'b0);
    applyStimulus(32'h4000, 32'h800, 6, 257, 1'b0);
    applyStimulus(32'h0, 32'h1000, 9, 512, 1'b0);

    $display("[TB] random frames");
    for (int r = 0; r < 12; r++) begin
      rb = $urandom;
      rs = $urandom_range(0, 32'h8000);
      rn = int'($urandom_range(EXT + 1, 20));
      rh = int'($urandom_range(1, 700));
      if ($urandom_range(0, 7) == 0) rn = int'($urandom_range(0, EXT));
      applyStimulus(rb, rs, rn, rh, 1'b0);
    end

    $display("[TB] reset mid frame");
    resetMidFrame();
    applyStimulus(32'h0, 32'h100, 8, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
